// File: rtl/serial_adder_pkg.sv
// Shared types and limits for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;

  localparam int SA_MAX_WIDTH = 64;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Single-bit full adder built from two half adders out of gate primitives.
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic carry_o
);

  logic halfSum;
  logic halfCarry;
  logic propCarry;

  xor xHalf (halfSum, a_i, b_i);
  and aHalf (halfCarry, a_i, b_i);
  xor xSum  (sum_o, halfSum, cin_i);
  and aProp (propCarry, halfSum, cin_i);
  or  oCarry(carry_o, halfCarry, propCarry);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell reused LSB-first over WIDTH cycles,
// with valid/ready handshakes on the operand and result sides.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  if (WIDTH < 1 || WIDTH > SA_MAX_WIDTH) begin : gBadWidth
    $error("serial_adder: WIDTH out of range");
  end

  sa_state_t        state_q;
  logic [WIDTH-1:0] shiftA_q;
  logic [WIDTH-1:0] shiftB_q;
  logic [WIDTH-1:0] sumSr_q;
  logic [WIDTH-1:0] sumSr_d;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             inReady_q;
  logic             outValid_q;
  logic [WIDTH-1:0] outSum_q;
  logic             outCout_q;
  logic             faSum;
  logic             faCarry;

  fa_cell uFa (
    .a_i     (shiftA_q[0]),
    .b_i     (shiftB_q[0]),
    .cin_i   (carry_q),
    .sum_o   (faSum),
    .carry_o (faCarry)
  );

  // New sum bits enter at the MSB so the LSB-first result lands aligned after WIDTH shifts.
  always_comb begin
    sumSr_d = sumSr_q >> 1;
    sumSr_d[WIDTH-1] = faSum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shiftA_q   <= '0;
      shiftB_q   <= '0;
      sumSr_q    <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
      outSum_q   <= '0;
      outCout_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            shiftA_q  <= in_a;
            shiftB_q  <= in_b;
            carry_q   <= in_cin;
            cnt_q     <= '0;
            sumSr_q   <= '0;
            inReady_q <= 1'b0;
            state_q   <= RUN;
          end
        end
        RUN: begin
          shiftA_q <= shiftA_q >> 1;
          shiftB_q <= shiftB_q >> 1;
          sumSr_q  <= sumSr_d;
          carry_q  <= faCarry;
          cnt_q    <= cnt_q + CNT_W'(1);
          // Result registers only update here, so a reset mid-run never exposes a partial sum.
          if (cnt_q == LAST_BIT) begin
            outValid_q <= 1'b1;
            outSum_q   <= sumSr_d;
            outCout_q  <= faCarry;
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = inReady_q;
  assign out_valid = outValid_q;
  assign out_sum   = outSum_q;
  assign out_cout  = outCout_q;

endmodule
